// File: rtl/insn_mem_resp_if.sv
// insn_mem_resp_if
//   Groups the fetch-side read handshake, the memory load (write) port and
//   the response signals of insn_mem_resp.
//   Signal names carry the direction as seen from the memory block:
//     i_rd_n      active-low read request
//     i_addr      word address of the requested instruction
//     i_flush     cancels any pending read
//     i_we_n      active-low write strobe for the load port
//     i_wr_addr   write word address
//     i_wr_data   write data
//     o_insn      returned instruction word, valid while o_rdy_n = 0
//     o_rdy_n     active-low one-cycle response strobe
//     o_busy      stall request while a read is outstanding
//     o_err       out-of-range address, qualified by o_rdy_n = 0
//   modport master : fetch stage / loader side
//   modport slave  : memory block side
interface insn_mem_resp_if;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;

  logic              i_rd_n;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic              i_we_n;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic [DATA_W-1:0] o_insn;
  logic              o_rdy_n;
  logic              o_busy;
  logic              o_err;

  modport master (
    output i_rd_n, i_addr, i_flush, i_we_n, i_wr_addr, i_wr_data,
    input  o_insn, o_rdy_n, o_busy, o_err
  );

  modport slave (
    input  i_rd_n, i_addr, i_flush, i_we_n, i_wr_addr, i_wr_data,
    output o_insn, o_rdy_n, o_busy, o_err
  );
endinterface

// File: rtl/insn_mem_resp.sv
// insn_mem_resp
//   Instruction memory with a programmable wait-state read response.
//   A read request is accepted in IDLE or READY, held for WAIT_CYCLES cycles
//   in WAIT (stalling the pipeline through o_busy) and answered with a
//   one-cycle o_rdy_n strobe in READY. The memory also has an independent
//   load port usable in any state. All outputs are registered.
//   Ports:
//     i_clk      single clock, rising edge
//     i_reset_n  synchronous active-low reset (memory contents are kept)
//     bus        insn_mem_resp_if.slave (request, load port, response)
//   Parameters:
//     WAIT_CYCLES      wait cycles before each response (0-15)
//     ADDR_DEPTH_LOG2  log2 of memory depth in words
module insn_mem_resp #(
  parameter int unsigned WAIT_CYCLES     = 2,
  parameter int unsigned ADDR_DEPTH_LOG2 = 10
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  insn_mem_resp_if.slave bus
);
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 32'd1 << ADDR_DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = WAIT_CYCLES[3:0];
  localparam bit          HAS_WAIT  = (WAIT_CYCLES != 32'd0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_cnt;
  logic [3:0]          w_next_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_next_addr;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic                w_rd_oor;
  logic                w_wr_oor;
  logic [DATA_W-1:0]   r_mem [0:DEPTH-1];
  logic [DATA_W-1:0]   r_insn;
  logic                r_rdy_n;
  logic                r_busy;
  logic                r_err;

  // Any address bit at or above the depth makes the word address out of range.
  function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
    return |(a >> ADDR_DEPTH_LOG2);
  endfunction

  // Next-state, counter and address-latch logic.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_addr  = r_addr;
    w_accept     = 1'b0;
    if (bus.i_flush) begin
      // flush beats everything, including a same-cycle request
      w_next_state = S_IDLE;
      w_next_cnt   = 4'd0;
    end else begin
      case (r_state)
        S_IDLE, S_READY: begin
          if (!bus.i_rd_n) begin
            w_accept     = 1'b1;
            w_next_addr  = bus.i_addr;
            w_next_cnt   = WAIT_INIT;
            w_next_state = HAS_WAIT ? S_WAIT : S_READY;
          end else begin
            w_next_state = S_IDLE;
          end
        end
        S_WAIT: begin
          // requests are ignored here; leave once the counter expires
          if (r_cnt <= 4'd1) begin
            w_next_state = S_READY;
            w_next_cnt   = 4'd0;
          end else begin
            w_next_cnt = r_cnt - 4'd1;
          end
        end
        default: begin
          w_next_state = S_IDLE;
          w_next_cnt   = 4'd0;
        end
      endcase
    end
  end

  // With zero wait cycles the read happens on the accepting edge itself,
  // before r_addr holds the new address, so take it straight from the bus.
  always_comb begin
    w_rd_addr = w_accept ? bus.i_addr : r_addr;
    w_rd_oor  = addr_oor(w_rd_addr);
    w_wr_oor  = addr_oor(bus.i_wr_addr);
  end

  // State, counter and registered response outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_insn  <= '0;
      r_rdy_n <= 1'b1;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_addr  <= w_next_addr;
      r_busy  <= (w_next_state == S_WAIT);
      if (w_next_state == S_READY) begin
        // non-blocking read sees the word before any same-edge write
        r_rdy_n <= 1'b0;
        r_err   <= w_rd_oor;
        r_insn  <= w_rd_oor ? '0 : r_mem[w_rd_addr[ADDR_DEPTH_LOG2-1:0]];
      end else begin
        r_rdy_n <= 1'b1;
        r_err   <= 1'b0;
        r_insn  <= '0;
      end
    end
  end

  // Load port: in-range writes in any state, dropped while in reset.
  always_ff @(posedge i_clk) begin
    if (!bus.i_we_n && i_reset_n && !w_wr_oor) begin
      r_mem[bus.i_wr_addr[ADDR_DEPTH_LOG2-1:0]] <= bus.i_wr_data;
    end
  end

  assign bus.o_insn  = r_insn;
  assign bus.o_rdy_n = r_rdy_n;
  assign bus.o_busy  = r_busy;
  assign bus.o_err   = r_err;
endmodule

// File: tb/tb_insn_mem_resp.sv
// tb_insn_mem_resp
//   Directed bench for insn_mem_resp. Instance u_dut_w2 uses two wait
//   cycles, u_dut_w0 uses none; both share clock and reset.
module tb_insn_mem_resp;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  insn_mem_resp_if bus_a ();
  insn_mem_resp_if bus_b ();

  insn_mem_resp #(.WAIT_CYCLES(2), .ADDR_DEPTH_LOG2(10)) u_dut_w2 (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus_a)
  );

  insn_mem_resp #(.WAIT_CYCLES(0), .ADDR_DEPTH_LOG2(10)) u_dut_w0 (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_both(input logic [29:0] a, input logic [31:0] d);
    bus_a.i_we_n = 1'b0; bus_a.i_wr_addr = a; bus_a.i_wr_data = d;
    bus_b.i_we_n = 1'b0; bus_b.i_wr_addr = a; bus_b.i_wr_data = d;
    step();
    bus_a.i_we_n = 1'b1;
    bus_b.i_we_n = 1'b1;
  endtask

  // Full two-wait-cycle read on bus_a with cycle-by-cycle checks.
  task automatic read_a(input string tag, input logic [29:0] a,
                        input logic [31:0] exp_insn, input logic exp_err);
    bus_a.i_rd_n = 1'b0; bus_a.i_addr = a;
    step();
    check_eq({tag, "_busy1"}, {31'd0, bus_a.o_busy}, 32'd1);
    bus_a.i_rd_n = 1'b1; bus_a.i_addr = 30'h3ABCDEF;
    step();
    check_eq({tag, "_busy2"}, {31'd0, bus_a.o_busy}, 32'd1);
    check_eq({tag, "_rdy_wait"}, {31'd0, bus_a.o_rdy_n}, 32'd1);
    step();
    check_eq({tag, "_rdy"}, {31'd0, bus_a.o_rdy_n}, 32'd0);
    check_eq({tag, "_insn"}, bus_a.o_insn, exp_insn);
    check_eq({tag, "_err"}, {31'd0, bus_a.o_err}, {31'd0, exp_err});
    check_eq({tag, "_busy_rdy"}, {31'd0, bus_a.o_busy}, 32'd0);
    step();
    check_eq({tag, "_idle_rdy"}, {31'd0, bus_a.o_rdy_n}, 32'd1);
    check_eq({tag, "_idle_insn"}, bus_a.o_insn, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus_a.i_rd_n = 1'b1; bus_a.i_addr = '0; bus_a.i_flush = 1'b0;
    bus_a.i_we_n = 1'b1; bus_a.i_wr_addr = '0; bus_a.i_wr_data = '0;
    bus_b.i_rd_n = 1'b1; bus_b.i_addr = '0; bus_b.i_flush = 1'b0;
    bus_b.i_we_n = 1'b1; bus_b.i_wr_addr = '0; bus_b.i_wr_data = '0;
    step(); step(); step();

    check_eq("rst_rdy", {31'd0, bus_a.o_rdy_n}, 32'd1);
    check_eq("rst_busy", {31'd0, bus_a.o_busy}, 32'd0);
    check_eq("rst_insn", bus_a.o_insn, 32'd0);
    check_eq("rst_err", {31'd0, bus_a.o_err}, 32'd0);
    check_eq("rst_rdy_w0", {31'd0, bus_b.o_rdy_n}, 32'd1);

    reset_n = 1'b1;
    wr_both(30'h099, 32'h0000_0001);
    wr_both(30'h000, 32'h0000_00A0);
    wr_both(30'h001, 32'h0000_00A1);
    wr_both(30'h002, 32'h0000_00A2);
    wr_both(30'h005, 32'h5555_0005);
    wr_both(30'h3FF, 32'h3FF0_0000);
    wr_both(30'h010, 32'h1010_1010);
    wr_both(30'h400, 32'hFFFF_FFFF);   // out of range, must not alias word 0

    // basic two-wait-cycle read
    read_a("basic", 30'h099, 32'h0000_0001, 1'b0);

    // zero-wait back-to-back stream
    bus_b.i_rd_n = 1'b0; bus_b.i_addr = 30'h000;
    step();
    check_eq("w0_rdy0", {31'd0, bus_b.o_rdy_n}, 32'd0);
    check_eq("w0_insn0", bus_b.o_insn, 32'h0000_00A0);
    check_eq("w0_busy0", {31'd0, bus_b.o_busy}, 32'd0);
    bus_b.i_addr = 30'h001;
    step();
    check_eq("w0_rdy1", {31'd0, bus_b.o_rdy_n}, 32'd0);
    check_eq("w0_insn1", bus_b.o_insn, 32'h0000_00A1);
    bus_b.i_addr = 30'h002;
    step();
    check_eq("w0_rdy2", {31'd0, bus_b.o_rdy_n}, 32'd0);
    check_eq("w0_insn2", bus_b.o_insn, 32'h0000_00A2);
    check_eq("w0_busy2", {31'd0, bus_b.o_busy}, 32'd0);
    bus_b.i_addr = 30'h400;
    step();
    check_eq("w0_oor_err", {31'd0, bus_b.o_err}, 32'd1);
    check_eq("w0_oor_insn", bus_b.o_insn, 32'd0);
    bus_b.i_rd_n = 1'b1;
    step();
    check_eq("w0_end_rdy", {31'd0, bus_b.o_rdy_n}, 32'd1);
    check_eq("w0_end_insn", bus_b.o_insn, 32'd0);

    // out-of-range boundary on the wait-state instance
    read_a("oor", 30'h400, 32'd0, 1'b1);
    read_a("top", 30'h3FF, 32'h3FF0_0000, 1'b0);

    // flush during WAIT cancels the response
    bus_a.i_rd_n = 1'b0; bus_a.i_addr = 30'h010;
    step();
    bus_a.i_rd_n = 1'b1; bus_a.i_flush = 1'b1;
    step();
    check_eq("flush_busy", {31'd0, bus_a.o_busy}, 32'd0);
    check_eq("flush_rdy", {31'd0, bus_a.o_rdy_n}, 32'd1);
    bus_a.i_flush = 1'b0;
    step();
    check_eq("flush_norsp1", {31'd0, bus_a.o_rdy_n}, 32'd1);
    step();
    check_eq("flush_norsp2", {31'd0, bus_a.o_rdy_n}, 32'd1);
    // flush overrides a same-cycle request
    bus_a.i_rd_n = 1'b0; bus_a.i_flush = 1'b1;
    step();
    check_eq("flush_ovr_busy", {31'd0, bus_a.o_busy}, 32'd0);
    bus_a.i_rd_n = 1'b1; bus_a.i_flush = 1'b0;
    step();
    read_a("after_flush", 30'h010, 32'h1010_1010, 1'b0);

    // write on the edge the read enters READY returns old data
    bus_a.i_rd_n = 1'b0; bus_a.i_addr = 30'h005;
    step();
    bus_a.i_rd_n = 1'b1;
    step();
    bus_a.i_we_n = 1'b0; bus_a.i_wr_addr = 30'h005; bus_a.i_wr_data = 32'hDEAD_BEEF;
    step();
    check_eq("rbw_old", bus_a.o_insn, 32'h5555_0005);
    bus_a.i_we_n = 1'b1;
    step();
    read_a("rbw_new", 30'h005, 32'hDEAD_BEEF, 1'b0);

    // reset mid-WAIT; a write during reset is dropped
    bus_a.i_rd_n = 1'b0; bus_a.i_addr = 30'h099;
    step();
    bus_a.i_rd_n = 1'b1;
    reset_n = 1'b0;
    bus_a.i_we_n = 1'b0; bus_a.i_wr_addr = 30'h099; bus_a.i_wr_data = 32'h0000_0BAD;
    step();
    check_eq("mrst_busy", {31'd0, bus_a.o_busy}, 32'd0);
    check_eq("mrst_rdy", {31'd0, bus_a.o_rdy_n}, 32'd1);
    check_eq("mrst_insn", bus_a.o_insn, 32'd0);
    reset_n = 1'b1;
    bus_a.i_we_n = 1'b1;
    step();
    check_eq("mrst_norsp1", {31'd0, bus_a.o_rdy_n}, 32'd1);
    step();
    check_eq("mrst_norsp2", {31'd0, bus_a.o_rdy_n}, 32'd1);
    read_a("mrst_mem", 30'h099, 32'h0000_0001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
